shift_exec_unit: RTL

Multi-cycle shift register that executes the 3-bit shift function codes produced by the shift-function source selection in the datapath. It holds a 32-bit operand, loads it on command, and applies SLL/SRL/SRA/ROR/ROL by a 5-bit amount, moving one bit position per clock. A start/busy/done handshake tells the control unit when the result on `dout` is final.

---
 rtl/shift_exec_unit_if.sv | 23 ++
 rtl/shift_exec_unit.sv | 107 ++++++++++
 2 files changed

// File: rtl/shift_exec_unit_if.sv
// Command/result bundle between the control unit (master) and the shift execution unit (slave).
interface shift_exec_unit_if #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned AMT_W = 5
);
    logic             start;
    logic [2:0]       func;
    logic [AMT_W-1:0] n;
    logic [WIDTH-1:0] din;
    logic [WIDTH-1:0] dout;
    logic             busy;
    logic             done;

    modport master (
        output start, func, n, din,
        input  dout, busy, done
    );

    modport slave (
        input  start, func, n, din,
        output dout, busy, done
    );
endinterface

// File: rtl/shift_exec_unit.sv
// Multi-cycle shifter: loads a word, then moves it one bit per clock for SLL/SRL/SRA/ROR/ROL.
module shift_exec_unit #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned AMT_W = 5
) (
    input  logic              clk,
    input  logic              reset_n,
    shift_exec_unit_if.slave  bus
);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] SHIFT = 1'b1;

    localparam logic [2:0] FN_NOP  = 3'b000;
    localparam logic [2:0] FN_LOAD = 3'b001;
    localparam logic [2:0] FN_SLL  = 3'b010;
    localparam logic [2:0] FN_SRL  = 3'b011;
    localparam logic [2:0] FN_SRA  = 3'b100;
    localparam logic [2:0] FN_ROR  = 3'b101;
    localparam logic [2:0] FN_ROL  = 3'b110;

    logic [0:0]       state_q, state_d;
    logic [WIDTH-1:0] dout_q,  dout_d;
    logic [AMT_W-1:0] cnt_q,   cnt_d;
    logic [2:0]       op_q,    op_d;
    logic             busy_q,  busy_d;
    logic             done_q,  done_d;

    // Single-position move for one shift clock.
    function automatic logic [WIDTH-1:0] one_step(input logic [2:0] op, input logic [WIDTH-1:0] d);
        logic [WIDTH-1:0] r;
        r = d;
        case (op)
            FN_SLL:  r = {d[WIDTH-2:0], 1'b0};
            FN_SRL:  r = {1'b0, d[WIDTH-1:1]};
            FN_SRA:  r = {d[WIDTH-1], d[WIDTH-1:1]};
            FN_ROR:  r = {d[0], d[WIDTH-1:1]};
            FN_ROL:  r = {d[WIDTH-2:0], d[WIDTH-1]};
            default: r = d;
        endcase
        return r;
    endfunction

    always_comb begin
        state_d = state_q;
        dout_d  = dout_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    case (bus.func)
                        FN_LOAD: begin
                            dout_d = bus.din;
                            done_d = 1'b1;
                        end
                        FN_SLL, FN_SRL, FN_SRA, FN_ROR, FN_ROL: begin
                            // A zero amount completes immediately without entering SHIFT.
                            if (bus.n == AMT_W'(0)) begin
                                done_d = 1'b1;
                            end else begin
                                op_d    = bus.func;
                                cnt_d   = bus.n;
                                state_d = SHIFT;
                            end
                        end
                        default: done_d = 1'b1;
                    endcase
                end
            end
            SHIFT: begin
                dout_d = one_step(op_q, dout_q);
                cnt_d  = cnt_q - AMT_W'(1);
                if (cnt_q == AMT_W'(1)) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d == SHIFT);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
            dout_q  <= '0;
            cnt_q   <= '0;
            op_q    <= FN_NOP;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            dout_q  <= dout_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.dout = dout_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;

endmodule
